arb_rr_hold: RTL and testbench

- Parametrised N-requester arbiter with a registered one-hot grant.
- Round-robin or fixed-priority selection, chosen at runtime.
- A grant is held while its request stays asserted, bounded by a maximum-hold timer.
- Sits in front of a shared resource (bus or memory port), replacing the combinational 5-input fixed-priority arbiter in new designs.

---
 rtl/arb_pkg.sv | 18 +
 rtl/arb_rr_pick.sv | 59 +++++
 rtl/arb_rr_hold.sv | 141 ++++++++++++++
 tb/tb_arb_rr_hold.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and types for the round-robin/hold arbiter
//
// Purpose : arbitration mode encodings and FSM state type shared by
//           arb_rr_pick and arb_rr_hold.
// Ports   : none (package).
package arb_pkg;

  // Encodings of the runtime mode input.
  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Arbiter FSM: IDLE has no owner, BUSY holds grant for owner grt_id.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - combinational winner search for the arbiter
//
// Purpose : picks one requester out of (req & ~mask). Round-robin mode
//           searches upward from ptr with wrap-around; fixed mode picks
//           the lowest set bit. Outputs are zero when nothing is eligible.
// Ports   :
//   req     in  N    request vector
//   mask    in  N    bits excluded from this search
//   ptr     in  IDW  round-robin start index (ignored in fixed mode)
//   mode    in  1    MODE_RR / MODE_FIXED
//   win     out N    one-hot winner, zero if none
//   win_id  out IDW  index of winner, zero if none
//   win_vld out 1    a winner was found
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int N   = 5,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] ptr,
  input  logic           mode,
  output logic [N-1:0]   win,
  output logic [IDW-1:0] win_id,
  output logic           win_vld
);

  logic [N-1:0]   cand;
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] dsel;
  int             start;

  // The candidate vector is duplicated so that an upward search starting at
  // ptr naturally wraps: bits below ptr in the low copy are masked off and
  // reappear, in order, in the high copy.
  always_comb begin
    cand  = req & ~mask;
    dbl   = {cand, cand};
    start = (mode == MODE_FIXED) ? 0 : int'(ptr);
    dsel  = '0;
    for (int i = 0; i < 2 * N; i++) begin
      dsel[i] = dbl[i] && (i >= start);
    end
  end

  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!win_vld && dsel[i]) begin
        win_vld = 1'b1;
        win_id  = IDW'(i % N);
      end
    end
    win = win_vld ? (N'(1) << win_id) : '0;
  end

endmodule

// File: rtl/arb_rr_hold.sv
// rtl/arb_rr_hold.sv - N-requester arbiter with held, time-limited grant
//
// Purpose : registered one-hot grant. The owner keeps the grant while it
//           requests, up to MAX_HOLD consecutive cycles (0 = unlimited).
//           Selection is round-robin or fixed priority, chosen per
//           arbitration by mode.
// Ports   :
//   clk     in  1    clock, rising edge
//   rst_    in  1    synchronous active-high reset
//   req     in  N    request vector
//   mode    in  1    0 = round-robin, 1 = fixed priority
//   grt     out N    registered grant, one-hot or zero
//   grt_vld out 1    grant present
//   grt_id  out IDW  index of granted requester, 0 when idle
module arb_rr_hold
  import arb_pkg::*;
#(
  parameter int N        = 5,
  parameter int MAX_HOLD = 16,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic [N-1:0]   req,
  input  logic           mode,
  output logic [N-1:0]   grt,
  output logic           grt_vld,
  output logic [IDW-1:0] grt_id
);

  // Counter only needs to reach MAX_HOLD; with no limit it just saturates.
  localparam int             CW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0]  HOLD_LIM = CW'(MAX_HOLD);
  localparam logic [CW-1:0]  CNT_MAX  = '1;

  state_t         state_q, state_d;
  logic [N-1:0]   grt_q, grt_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           arb_en;
  logic [N-1:0]   arb_mask;
  logic [N-1:0]   pick_win;
  logic [IDW-1:0] pick_id;
  logic           pick_vld;
  logic           owner_req;
  logic           timeout;

  arb_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req     (req),
    .mask    (arb_mask),
    .ptr     (ptr_q),
    .mode    (mode),
    .win     (pick_win),
    .win_id  (pick_id),
    .win_vld (pick_vld)
  );

  always_comb begin
    owner_req = |(req & grt_q);
    timeout   = (MAX_HOLD != 0) && (cnt_q >= HOLD_LIM);
  end

  always_comb begin
    state_d  = state_q;
    grt_d    = grt_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    arb_en   = 1'b0;
    arb_mask = '0;

    case (state_q)
      IDLE: begin
        arb_en = 1'b1;
      end
      BUSY: begin
        if (!owner_req) begin
          // Release: re-arbitrate on this edge so there is no idle bubble.
          arb_en = 1'b1;
        end else if (timeout) begin
          // Hold limit reached: others get a chance; owner is masked out.
          arb_en   = 1'b1;
          arb_mask = grt_q;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grt_d   = '0;
        id_d    = '0;
        cnt_d   = '0;
      end
    endcase

    if (arb_en) begin
      if (pick_vld) begin
        state_d = BUSY;
        grt_d   = pick_win;
        id_d    = pick_id;
        cnt_d   = CW'(1);
        // Pointer advances on every new grant, in both modes.
        ptr_d   = (int'(pick_id) == N - 1) ? '0 : pick_id + 1'b1;
      end else if (state_q == BUSY && owner_req) begin
        // Timeout with nobody else waiting: owner keeps it, window restarts.
        cnt_d = CW'(1);
      end else begin
        state_d = IDLE;
        grt_d   = '0;
        id_d    = '0;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q <= IDLE;
      grt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grt_q   <= grt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grt     = grt_q;
  assign grt_vld = |grt_q;
  assign grt_id  = id_q;

endmodule

// File: tb/tb_arb_rr_hold.sv
// tb/tb_arb_rr_hold.sv - directed self-checking bench for arb_rr_hold
module tb_arb_rr_hold;

  localparam int N   = 5;
  localparam int IDW = $clog2(N);

  logic           clk;
  logic           rst_;
  logic [N-1:0]   req;
  logic           mode;

  logic [N-1:0]   grt_a, grt_b;
  logic           vld_a, vld_b;
  logic [IDW-1:0] id_a, id_b;

  int n_vec;
  int n_err;

  // Bounded-hold instance (MAX_HOLD = 4) and unlimited-hold instance.
  arb_rr_hold #(.N(N), .MAX_HOLD(4)) u_dut (
    .clk     (clk),
    .rst_    (rst_),
    .req     (req),
    .mode    (mode),
    .grt     (grt_a),
    .grt_vld (vld_a),
    .grt_id  (id_a)
  );

  arb_rr_hold #(.N(N), .MAX_HOLD(0)) u_dut_nolim (
    .clk     (clk),
    .rst_    (rst_),
    .req     (req),
    .mode    (mode),
    .grt     (grt_b),
    .grt_vld (vld_b),
    .grt_id  (id_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ = 1'b1;
    req  = '0;
    mode = 1'b0;
    tick();
    tick();
    rst_ = 1'b0;
  endtask

  logic [N-1:0] exp_g;
  logic [N-1:0] prev_req;
  int           wait_cnt [N];
  int           max_wait;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_  = 1'b1;
    req   = '0;
    mode  = 1'b0;

    // Reset state
    do_reset();
    chk("rst_grt", grt_a, 0);
    chk("rst_vld", vld_a, 0);
    chk("rst_id",  id_a,  0);

    // First grant, 1-cycle latency
    req = 5'b10100;
    tick();
    chk("first_grt", grt_a, 5'b00100);
    chk("first_id",  id_a,  2);
    chk("first_vld", vld_a, 1);

    // Release by owner 2: search from pointer 3 finds 4, no bubble
    req = 5'b10001;
    tick();
    chk("rel_grt", grt_a, 5'b10000);
    chk("rel_id",  id_a,  4);

    // Release by owner 4: wraps to 0
    req = 5'b00001;
    tick();
    chk("wrap_grt", grt_a, 5'b00001);
    chk("wrap_id",  id_a,  0);

    // Hold limit of 4 alternates two constant requesters
    do_reset();
    req = 5'b00011;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_g = (((k - 1) / 4) % 2 == 1) ? 5'b00010 : 5'b00001;
      chk($sformatf("alt_%0d", k), grt_a, exp_g);
    end

    // Sole requester times out but keeps the grant
    req = 5'b00001;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("solo_%0d", k), grt_a, 5'b00001);
    end
    chk("solo_vld", vld_a, 1);

    // Fixed priority, unlimited hold: lowest index held forever
    do_reset();
    mode = 1'b1;
    req  = 5'b11110;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("fix_%0d", k), grt_b, 5'b00010);
    end
    req = 5'b11100;
    tick();
    chk("fix_drop_grt", grt_b, 5'b00100);
    chk("fix_drop_id",  id_b,  2);

    // Mode change while busy has no effect on current owner
    mode = 1'b0;
    tick();
    chk("mode_busy", grt_b, 5'b00100);

    // Reach owner 3, then reset mid-grant
    mode = 1'b1;
    req  = 5'b11000;
    tick();
    chk("pre_rst_grt", grt_b, 5'b01000);
    rst_ = 1'b1;
    tick();
    chk("midrst_grt", grt_b, 0);
    chk("midrst_vld", vld_b, 0);
    chk("midrst_id",  id_b,  0);
    rst_ = 1'b0;
    mode = 1'b0;
    req  = 5'b11111;
    tick();
    chk("post_rst_a", grt_a, 5'b00001);
    chk("post_rst_b", grt_b, 5'b00001);

    // Random RR traffic: requests held until served, owners drop randomly
    do_reset();
    mode = 1'b0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    max_wait = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (grt_a[i]) req[i] = ($urandom_range(3) != 0);
        else if (!req[i]) req[i] = ($urandom_range(2) == 0);
      end
      prev_req = req;
      tick();
      chk("rnd_onehot", 32'($onehot0(grt_a)), 1);
      chk("rnd_causal", 32'(grt_a & ~prev_req), 0);
      chk("rnd_vld", vld_a, 32'(grt_a != 0));
      for (int i = 0; i < N; i++) begin
        if (prev_req[i] && !grt_a[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end
    chk("rnd_max_wait", 32'(max_wait <= (N - 1) * 4 + N), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
